mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the data port of the unified byte-addressed memory (address/data/writeMode/readMode/unsignedLoad; combinational read, write on clock edge).
- Requester 0 is the CPU load/store unit; requester 1 is the debug/program loader.
- Grants one access at a time, drives the memory data port, and returns registered read data to the granted requester.
- The instruction-fetch port (pcAddress) is not touched by this block.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the memory data port: CPU (0) and debug loader (1).
// One access per two cycles; read data is registered back to the granted requester.
module mem_port_arbiter #(
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned AW = 32,
    localparam int unsigned DW = 32,
    localparam int unsigned MW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0Valid,
    input  logic [AW-1:0] req0Address,
    input  logic [DW-1:0] req0Data,
    input  logic [MW-1:0] req0WriteMode,
    input  logic [MW-1:0] req0ReadMode,
    input  logic          req0Unsigned,
    output logic          req0Ready,
    output logic          req0RValid,
    output logic [DW-1:0] req0RData,
    input  logic          req1Valid,
    input  logic [AW-1:0] req1Address,
    input  logic [DW-1:0] req1Data,
    input  logic [MW-1:0] req1WriteMode,
    input  logic [MW-1:0] req1ReadMode,
    input  logic          req1Unsigned,
    output logic          req1Ready,
    output logic          req1RValid,
    output logic [DW-1:0] req1RData,
    output logic [AW-1:0] memAddress,
    output logic [DW-1:0] memData,
    output logic [MW-1:0] memWriteMode,
    output logic [MW-1:0] memReadMode,
    output logic          memUnsigned,
    input  logic [DW-1:0] memDataOutput,
    output logic          busy
);

    localparam int unsigned CW = 8;
    localparam logic [MW-1:0] MODE_NONE = '0;
    localparam logic [CW-1:0] LIMIT     = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          pick1;

    // Arbitration, grant sequencing, memory port drive and read capture.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        starve_d     = starve_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        memAddress   = '0;
        memData      = '0;
        memWriteMode = MODE_NONE;
        memReadMode  = MODE_NONE;
        memUnsigned  = 1'b0;
        req0Ready    = 1'b0;
        req1Ready    = 1'b0;

        // Tie-break: round-robin favours the other side; fixed favours 0 until 1 starves.
        if (ARB_MODE == 0) begin
            pick1 = ~last_q;
        end else begin
            pick1 = (starve_q == LIMIT);
        end

        case (state_q)
            IDLE: begin
                if (req0Valid && req1Valid) begin
                    state_d = pick1 ? GRANT1 : GRANT0;
                end else if (req0Valid) begin
                    state_d = GRANT0;
                end else if (req1Valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                state_d = IDLE;
                if (req0Valid) begin
                    memAddress   = req0Address;
                    memData      = req0Data;
                    memWriteMode = req0WriteMode;
                    memReadMode  = req0ReadMode;
                    memUnsigned  = req0Unsigned;
                    req0Ready    = 1'b1;
                    last_d       = 1'b0;
                    if (req0ReadMode != MODE_NONE) begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = memDataOutput;
                    end
                end
            end
            GRANT1: begin
                state_d = IDLE;
                if (req1Valid) begin
                    memAddress   = req1Address;
                    memData      = req1Data;
                    memWriteMode = req1WriteMode;
                    memReadMode  = req1ReadMode;
                    memUnsigned  = req1Unsigned;
                    req1Ready    = 1'b1;
                    last_d       = 1'b1;
                    if (req1ReadMode != MODE_NONE) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = memDataOutput;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ARB_MODE == 0) begin
            starve_d = '0;
        end else if (state_q == GRANT1) begin
            starve_d = '0;
        end else if (req1Valid && (starve_q != LIMIT)) begin
            starve_d = starve_q + CW'(1);
        end

        // Reset abandons any in-flight grant: no write, no handshake.
        if (rst) begin
            memAddress   = '0;
            memData      = '0;
            memWriteMode = MODE_NONE;
            memReadMode  = MODE_NONE;
            memUnsigned  = 1'b0;
            req0Ready    = 1'b0;
            req1Ready    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            starve_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            starve_q  <= starve_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign busy       = (state_q != IDLE) && !rst;
    assign req0RValid = rvalid0_q && !rst;
    assign req1RValid = rvalid1_q && !rst;
    assign req0RData  = rdata0_q;
    assign req1RData  = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance, each with its own
// byte memory, checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  wm;
        logic [2:0]  rm;
        logic        uns;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    req_t        rq [2][2];
    logic        rdy [2][2];
    logic        rv [2][2];
    logic [31:0] rd [2][2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic [31:0] m_rdout [2];
    logic [2:0]  m_wm [2];
    logic [2:0]  m_rm [2];
    logic        m_uns [2];
    logic        bsy [2];

    int n_total = 0;
    int n_bad   = 0;

    int          m_gr [2];
    int          m_last [2];
    int          m_wait [2];
    int          lim [2];
    bit          m_rv [2][2];
    logic [31:0] m_rd [2][2];
    bit          acc [2][2];
    logic [7:0]  ref_mem [2][1024];

    always #5 clk = ~clk;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] rm, input logic uns);
        case (rm)
            3'd0:    return 32'd0;
            3'd1:    return uns ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            3'd2:    return uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] wmask(input logic [2:0] wm);
        case (wm)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [7:0] env_mem [1024];
        wire  [9:0] ea = m_addr[gi][9:0];
        wire  [3:0] we = wmask(m_wm[gi]);

        mem_port_arbiter #(.ARB_MODE(gi), .STARVE_LIMIT(gi == 0 ? 8 : 3)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req0Valid    (rq[gi][0].valid),
            .req0Address  (rq[gi][0].addr),
            .req0Data     (rq[gi][0].data),
            .req0WriteMode(rq[gi][0].wm),
            .req0ReadMode (rq[gi][0].rm),
            .req0Unsigned (rq[gi][0].uns),
            .req0Ready    (rdy[gi][0]),
            .req0RValid   (rv[gi][0]),
            .req0RData    (rd[gi][0]),
            .req1Valid    (rq[gi][1].valid),
            .req1Address  (rq[gi][1].addr),
            .req1Data     (rq[gi][1].data),
            .req1WriteMode(rq[gi][1].wm),
            .req1ReadMode (rq[gi][1].rm),
            .req1Unsigned (rq[gi][1].uns),
            .req1Ready    (rdy[gi][1]),
            .req1RValid   (rv[gi][1]),
            .req1RData    (rd[gi][1]),
            .memAddress   (m_addr[gi]),
            .memData      (m_data[gi]),
            .memWriteMode (m_wm[gi]),
            .memReadMode  (m_rm[gi]),
            .memUnsigned  (m_uns[gi]),
            .memDataOutput(m_rdout[gi]),
            .busy         (bsy[gi])
        );

        // Little-endian byte memory: combinational read, write on the clock edge.
        assign m_rdout[gi] = extend({env_mem[ea + 10'd3], env_mem[ea + 10'd2],
                                     env_mem[ea + 10'd1], env_mem[ea]}, m_rm[gi], m_uns[gi]);

        always @(posedge clk) begin
            if (mem_clr) begin
                for (int n = 0; n < 1024; n++) env_mem[n] <= 8'h00;
            end else begin
                for (int j = 0; j < 4; j++)
                    if (we[j]) env_mem[ea + 10'(j)] <= m_data[gi][8*j +: 8];
            end
        end
    end

    function automatic logic [31:0] ref_load(input int i, input logic [31:0] a, input logic [2:0] rm,
                                             input logic uns);
        logic [9:0] aa;
        aa = a[9:0];
        return extend({ref_mem[i][aa + 10'd3], ref_mem[i][aa + 10'd2],
                       ref_mem[i][aa + 10'd1], ref_mem[i][aa]}, rm, uns);
    endfunction

    task automatic ref_store(input int i, input logic [31:0] a, input logic [31:0] d, input logic [2:0] wm);
        logic [3:0] mk;
        logic [9:0] aa;
        mk = wmask(wm);
        aa = a[9:0];
        for (int j = 0; j < 4; j++)
            if (mk[j]) ref_mem[i][aa + 10'(j)] = d[8*j +: 8];
    endtask

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Compare one instance against the model for this cycle, then advance the model over the edge.
    task automatic check_inst(input int i);
        string       p;
        logic [70:0] eb;
        logic [70:0] gb;
        bit          er [2];
        bit          nrv [2];
        int          ngr;
        int          k;
        bit          v0, v1;
        p  = (i == 0) ? "rr" : "fx";
        eb = '0;
        for (int kk = 0; kk < 2; kk++) begin
            er[kk] = !rst && (m_gr[i] == kk) && rq[i][kk].valid;
            if (er[kk]) eb = {rq[i][kk].addr, rq[i][kk].data, rq[i][kk].wm, rq[i][kk].rm, rq[i][kk].uns};
        end
        gb = {m_addr[i], m_data[i], m_wm[i], m_rm[i], m_uns[i]};
        check_eq({p, "_busy"}, 80'(bsy[i]), 80'(!rst && (m_gr[i] != -1)));
        for (int kk = 0; kk < 2; kk++) begin
            check_eq($sformatf("%s_ready%0d", p, kk), 80'(rdy[i][kk]), 80'(er[kk]));
            check_eq($sformatf("%s_rvalid%0d", p, kk), 80'(rv[i][kk]), 80'(!rst && m_rv[i][kk]));
            if (!rst) check_eq($sformatf("%s_rdata%0d", p, kk), 80'(rd[i][kk]), 80'(m_rd[i][kk]));
        end
        check_eq({p, "_membus"}, 80'(gb), 80'(eb));

        v0 = rq[i][0].valid;
        v1 = rq[i][1].valid;
        acc[i][0] = er[0];
        acc[i][1] = er[1];
        if (rst) begin
            m_gr[i]   = -1;
            m_last[i] = 1;
            m_wait[i] = 0;
            for (int kk = 0; kk < 2; kk++) begin
                m_rv[i][kk] = 1'b0;
                m_rd[i][kk] = 32'd0;
            end
        end else begin
            nrv[0] = 1'b0;
            nrv[1] = 1'b0;
            ngr    = -1;
            if (m_gr[i] >= 0) begin
                k = m_gr[i];
                if (er[k]) begin
                    m_last[i] = k;
                    if (rq[i][k].rm != 3'd0) begin
                        nrv[k]    = 1'b1;
                        m_rd[i][k] = ref_load(i, rq[i][k].addr, rq[i][k].rm, rq[i][k].uns);
                    end
                    ref_store(i, rq[i][k].addr, rq[i][k].data, rq[i][k].wm);
                end
            end else if (v0 && v1) begin
                if (i == 0) ngr = (m_last[i] == 0) ? 1 : 0;
                else        ngr = (m_wait[i] == lim[i]) ? 1 : 0;
            end else if (v0) begin
                ngr = 0;
            end else if (v1) begin
                ngr = 1;
            end
            if (i == 1) begin
                if (m_gr[i] == 1) m_wait[i] = 0;
                else if (v1 && (m_wait[i] < lim[i])) m_wait[i]++;
            end
            m_gr[i]    = ngr;
            m_rv[i][0] = nrv[0];
            m_rv[i][1] = nrv[1];
        end
    endtask

    // Inputs for a cycle are applied at the falling edge before calling this.
    task automatic cycle();
        #1;
        check_inst(0);
        check_inst(1);
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wm, input logic [2:0] rm, input logic uns);
        for (int i = 0; i < 2; i++) rq[i][k] = {v, a, d, wm, rm, uns};
    endtask

    task automatic run_req(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wm, input logic [2:0] rm, input logic uns);
        bit done [2];
        int lat [2];
        done[0] = 1'b0; done[1] = 1'b0;
        lat[0]  = -1;   lat[1]  = -1;
        set_req(k, 1'b1, a, d, wm, rm, uns);
        for (int n = 0; n < 10 && !(done[0] && done[1]); n++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (!done[i] && acc[i][k]) begin
                    done[i] = 1'b1;
                    lat[i]  = n;
                    rq[i][k].valid = 1'b0;
                end
            end
        end
        for (int i = 0; i < 2; i++) rq[i][k].valid = 1'b0;
        check_eq("rr_ready_latency", 80'(lat[0]), 80'(1));
        check_eq("fx_ready_latency", 80'(lat[1]), 80'(1));
        cycle();
        cycle();
    endtask

    task automatic drive_random();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!rq[i][k].valid || acc[i][k]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        rq[i][k].valid = 1'b1;
                        rq[i][k].addr  = 32'($urandom_range(0, 1023));
                        rq[i][k].data  = $urandom;
                        rq[i][k].wm    = 3'($urandom_range(0, 3));
                        rq[i][k].rm    = 3'($urandom_range(0, 3));
                        rq[i][k].uns   = 1'($urandom_range(0, 1));
                    end else begin
                        rq[i][k].valid = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        int cnt [2][2];
        rst     = 1'b1;
        mem_clr = 1'b1;
        lim[0]  = 8;
        lim[1]  = 3;
        for (int i = 0; i < 2; i++) begin
            m_gr[i]   = -1;
            m_last[i] = 1;
            m_wait[i] = 0;
            for (int k = 0; k < 2; k++) begin
                rq[i][k]   = '0;
                m_rv[i][k] = 1'b0;
                m_rd[i][k] = 32'd0;
                acc[i][k]  = 1'b0;
            end
            for (int n = 0; n < 1024; n++) ref_mem[i][n] = 8'h00;
        end
        @(negedge clk);
        repeat (3) cycle();
        rst     = 1'b0;
        mem_clr = 1'b0;
        cycle();

        // CPU word write then read back
        run_req(0, 32'h100, 32'hDEADBEEF, 3'd3, 3'd0, 1'b0);
        run_req(0, 32'h100, 32'h0, 3'd0, 3'd3, 1'b0);
        check_eq("rr_cpu_word", 80'(rd[0][0]), 80'(32'hDEADBEEF));
        check_eq("fx_cpu_word", 80'(rd[1][0]), 80'(32'hDEADBEEF));
        run_req(1, 32'h104, 32'hCAFEF00D, 3'd3, 3'd0, 1'b0);

        // Continuous contention from a fresh reset
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 32'h100, 32'h0, 3'd0, 3'd3, 1'b0);
        set_req(1, 1'b1, 32'h104, 32'h0, 3'd0, 3'd3, 1'b0);
        for (int i = 0; i < 2; i++) for (int k = 0; k < 2; k++) cnt[i][k] = 0;
        for (int n = 0; n < 8; n++) begin
            cycle();
            for (int i = 0; i < 2; i++) for (int k = 0; k < 2; k++) if (acc[i][k]) cnt[i][k]++;
        end
        set_req(0, 1'b0, 32'h100, 32'h0, 3'd0, 3'd3, 1'b0);
        set_req(1, 1'b0, 32'h104, 32'h0, 3'd0, 3'd3, 1'b0);
        cycle();
        cycle();
        check_eq("rr_grants0", 80'(cnt[0][0]), 80'(2));
        check_eq("rr_grants1", 80'(cnt[0][1]), 80'(2));
        check_eq("fx_grants0", 80'(cnt[1][0]), 80'(3));
        check_eq("fx_grants1", 80'(cnt[1][1]), 80'(1));
        check_eq("rr_nocross0", 80'(rd[0][0]), 80'(32'hDEADBEEF));
        check_eq("rr_nocross1", 80'(rd[0][1]), 80'(32'hCAFEF00D));

        // Signed and unsigned byte loads by the loader
        run_req(1, 32'h200, 32'h80, 3'd1, 3'd0, 1'b0);
        run_req(1, 32'h200, 32'h0, 3'd0, 3'd1, 1'b0);
        check_eq("rr_byte_signed", 80'(rd[0][1]), 80'(32'hFFFFFF80));
        check_eq("fx_byte_signed", 80'(rd[1][1]), 80'(32'hFFFFFF80));
        run_req(1, 32'h200, 32'h0, 3'd0, 3'd1, 1'b1);
        check_eq("rr_byte_unsigned", 80'(rd[0][1]), 80'(32'h00000080));
        check_eq("fx_byte_unsigned", 80'(rd[1][1]), 80'(32'h00000080));

        // Reset lands on the grant cycle of a write
        run_req(0, 32'h300, 32'hA5A5A5A5, 3'd3, 3'd0, 1'b0);
        set_req(0, 1'b1, 32'h300, 32'h12345678, 3'd3, 3'd0, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        set_req(0, 1'b0, 32'h300, 32'h12345678, 3'd3, 3'd0, 1'b0);
        cycle();
        rst = 1'b0;
        cycle();
        run_req(0, 32'h300, 32'h0, 3'd0, 3'd3, 1'b0);
        check_eq("rr_abort_keeps_old", 80'(rd[0][0]), 80'(32'hA5A5A5A5));
        check_eq("fx_abort_keeps_old", 80'(rd[1][0]), 80'(32'hA5A5A5A5));

        // Loader drops valid during its grant
        set_req(1, 1'b1, 32'h104, 32'h0, 3'd0, 3'd3, 1'b0);
        cycle();
        set_req(1, 1'b0, 32'h104, 32'h0, 3'd0, 3'd3, 1'b0);
        cycle();
        cycle();
        cycle();
        check_eq("rr_drop_no_capture", 80'(rd[0][1]), 80'(32'h0));
        check_eq("fx_drop_no_capture", 80'(rd[1][1]), 80'(32'h0));

        // Random traffic with occasional resets
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive_random();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
